// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: Wishbone-mapped controller for NUM_BANKS banks of BANK_W user IO pads.
// Each bank has registered pad outputs, active-low output enables, a synchronized
// input view, and per-bit sticky edge flags that are folded into one irq per bank.
//
// Register map (bank b at BASE_ADDR + b*0x20):
//   0x00 OUT (RW), 0x04 OEB (RW), 0x08 IN (RO), 0x0C IRQ_EN (RW), 0x10 IRQ_STAT (W1C),
//   0x14 EDGE (RW, only with IO_BANK_EDGE_SEL_EN; 0 = rising, 1 = falling).
// Any other offset inside the 256-byte window is acked, reads 0 and ignores writes.
//
// Optional feature macro: IO_BANK_EDGE_SEL_EN (per-bit edge polarity select).
//
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   wbs_stb/cyc/we/sel/dat/adr Wishbone slave request
//   wbs_ack_o, wbs_dat_o       Wishbone response (registered)
//   io_in / io_out / io_oeb    pad slices, bank b = [b*BANK_W +: BANK_W]
//   irq                        per-bank level interrupt

// Per-bank register file, input synchronizer and edge-flag logic.
module io_bank #(
  parameter int BANK_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [2:0]        reg_idx_i,
  input  logic [BANK_W-1:0] wdata_i,
  input  logic [BANK_W-1:0] wmask_i,
  input  logic [BANK_W-1:0] pad_i,
  output logic [BANK_W-1:0] out_o,
  output logic [BANK_W-1:0] oeb_o,
  output logic [BANK_W-1:0] rdata_o,
  output logic              irq_o
);
  logic [BANK_W-1:0] out_q, out_d, oeb_q, oeb_d, en_q, en_d, stat_q, stat_d;
  logic [BANK_W-1:0] s1_q, s2_q, s3_q, edge_hit;
  logic              irq_q;
`ifdef IO_BANK_EDGE_SEL_EN
  logic [BANK_W-1:0] esel_q, esel_d;
`endif

  // s2 is the synchronized pad value; s3 is its previous sample for edge detection.
`ifdef IO_BANK_EDGE_SEL_EN
  assign edge_hit = (esel_q & s3_q & ~s2_q) | (~esel_q & s2_q & ~s3_q);
`else
  assign edge_hit = s2_q & ~s3_q;
`endif

  always_comb begin
    out_d  = out_q;
    oeb_d  = oeb_q;
    en_d   = en_q;
    stat_d = stat_q;
`ifdef IO_BANK_EDGE_SEL_EN
    esel_d = esel_q;
`endif
    if (wr_en_i) begin
      case (reg_idx_i)
        3'd0: out_d  = (out_q & ~wmask_i) | (wdata_i & wmask_i);
        3'd1: oeb_d  = (oeb_q & ~wmask_i) | (wdata_i & wmask_i);
        3'd3: en_d   = (en_q  & ~wmask_i) | (wdata_i & wmask_i);
        3'd4: stat_d = stat_q & ~(wdata_i & wmask_i);
`ifdef IO_BANK_EDGE_SEL_EN
        3'd5: esel_d = (esel_q & ~wmask_i) | (wdata_i & wmask_i);
`endif
        default: ;
      endcase
    end
    // A new edge overrides a simultaneous clear so no event is lost.
    stat_d = stat_d | edge_hit;
  end

  always_comb begin
    rdata_o = '0;
    case (reg_idx_i)
      3'd0: rdata_o = out_q;
      3'd1: rdata_o = oeb_q;
      3'd2: rdata_o = s2_q;
      3'd3: rdata_o = en_q;
      3'd4: rdata_o = stat_q;
`ifdef IO_BANK_EDGE_SEL_EN
      3'd5: rdata_o = esel_q;
`endif
      default: rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      oeb_q  <= '1;
      en_q   <= '0;
      stat_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      irq_q  <= 1'b0;
`ifdef IO_BANK_EDGE_SEL_EN
      esel_q <= '0;
`endif
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      s1_q   <= pad_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      irq_q  <= |(stat_q & en_q);
`ifdef IO_BANK_EDGE_SEL_EN
      esel_q <= esel_d;
`endif
    end
  end

  assign out_o = out_q;
  assign oeb_o = oeb_q;
  assign irq_o = irq_q;
endmodule

module io_bank_ctrl #(
  parameter int          NUM_BANKS = 3,
  parameter int          BANK_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_dat_i,
  input  logic [31:0]                 wbs_adr_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic [NUM_BANKS*BANK_W-1:0] io_in,
  output logic [NUM_BANKS*BANK_W-1:0] io_out,
  output logic [NUM_BANKS*BANK_W-1:0] io_oeb,
  output logic [NUM_BANKS-1:0]        irq
);
  logic                              hit, req, wr_commit;
  logic [2:0]                        bank_sel, reg_idx;
  logic [BANK_W-1:0]                 wmask, rd_mux;
  logic [NUM_BANKS-1:0][BANK_W-1:0]  rd_bank;
  logic                              ack_q, ack_d;
  logic [31:0]                       dat_q, dat_d;
  logic                              unused_bits;

  assign hit      = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req      = wbs_stb_i & wbs_cyc_i & hit;
  assign bank_sel = wbs_adr_i[7:5];
  assign reg_idx  = wbs_adr_i[4:2];
  // The master holds the request through the ack cycle; the write lands at its end.
  assign wr_commit = req & ack_q & wbs_we_i;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < BANK_W; i++) wmask[i] = wbs_sel_i[i/8];
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_sel == 3'(b)) rd_mux = rd_bank[b];
  end

  // Ack on alternate cycles only: a held strobe re-arms after the ack drops.
  assign ack_d = req & ~ack_q;
  assign dat_d = (ack_d & ~wbs_we_i) ? 32'(rd_mux) : 32'd0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    io_bank #(.BANK_W(BANK_W)) u_bank (
      .clk_i     (wb_clk_i),
      .rst_n_i   (wb_rst_n_i),
      .wr_en_i   (wr_commit && (bank_sel == 3'(b))),
      .reg_idx_i (reg_idx),
      .wdata_i   (wbs_dat_i[BANK_W-1:0]),
      .wmask_i   (wmask),
      .pad_i     (io_in[b*BANK_W +: BANK_W]),
      .out_o     (io_out[b*BANK_W +: BANK_W]),
      .oeb_o     (io_oeb[b*BANK_W +: BANK_W]),
      .rdata_o   (rd_bank[b]),
      .irq_o     (irq[b])
    );
  end
endmodule

// File: tb/tb_io_bank_ctrl.sv
module tb_io_bank_ctrl;
  localparam int NB = 3;
  localparam int BW = 8;
  localparam int W  = NB*BW;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = '0;
  logic [31:0]   dat_i = '0, adr = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [W-1:0]  io_in = '0;
  logic [W-1:0]  io_out, io_oeb;
  logic [NB-1:0] irq;

  always #5 clk = ~clk;

  io_bank_ctrl #(.NUM_BANKS(NB), .BANK_W(BW), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: register contents per bank plus the last settled pad value.
  logic [BW-1:0] m_out[NB], m_oeb[NB], m_en[NB], m_stat[NB], m_esel[NB];
  logic [W-1:0]  m_pad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] A(input int b, input int i);
    return BASE + 32'(b*32 + i*4);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_out[b] = '0; m_oeb[b] = '1; m_en[b] = '0; m_stat[b] = '0; m_esel[b] = '0;
    end
    m_pad = '0;
  endtask

  task automatic model_write(input int b, input int i, input logic [31:0] d, input logic [3:0] s);
    logic [BW-1:0] m, v;
    for (int k = 0; k < BW; k++) m[k] = s[k/8];
    v = d[BW-1:0];
    if (b < NB) begin
      case (i)
        0: m_out[b] = (m_out[b] & ~m) | (v & m);
        1: m_oeb[b] = (m_oeb[b] & ~m) | (v & m);
        3: m_en[b]  = (m_en[b] & ~m) | (v & m);
        4: m_stat[b] = m_stat[b] & ~(v & m);
`ifdef IO_BANK_EDGE_SEL_EN
        5: m_esel[b] = (m_esel[b] & ~m) | (v & m);
`endif
        default: ;
      endcase
    end
  endtask

  // New settled pad value: flag every bit whose selected edge occurred.
  task automatic model_pads(input logic [W-1:0] nw);
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < BW; k++) begin
        logic o, n;
        o = m_pad[b*BW+k];
        n = nw[b*BW+k];
        if (m_esel[b][k] ? (o && !n) : (!o && n)) m_stat[b][k] = 1'b1;
      end
    m_pad = nw;
  endtask

  function automatic logic [31:0] model_read(input int b, input int i);
    if (b >= NB) return 32'd0;
    case (i)
      0: return 32'(m_out[b]);
      1: return 32'(m_oeb[b]);
      2: return 32'(m_pad[b*BW +: BW]);
      3: return 32'(m_en[b]);
      4: return 32'(m_stat[b]);
`ifdef IO_BANK_EDGE_SEL_EN
      5: return 32'(m_esel[b]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_pins(input string tag);
    logic [W-1:0] eo, ee;
    logic [NB-1:0] ei;
    for (int b = 0; b < NB; b++) begin
      eo[b*BW +: BW] = m_out[b];
      ee[b*BW +: BW] = m_oeb[b];
      ei[b] = |(m_stat[b] & m_en[b]);
    end
    chk({tag, "_out"}, 32'(io_out), 32'(eo));
    chk({tag, "_oeb"}, 32'(io_oeb), 32'(ee));
    chk({tag, "_irq"}, 32'(irq), 32'(ei));
  endtask

  // Starts just after a rising edge; holds the request through the ack cycle.
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic acked, output logic [31:0] rd);
    acked = 1'b0; rd = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int k = 0; k < 6 && !acked; k++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; rd = dat_o; end
    end
    if (acked) begin @(posedge clk); #1; end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int b, input int i, input logic [31:0] d, input logic [3:0] s);
    logic ok; logic [31:0] r;
    wb(1'b1, A(b, i), d, s, ok, r);
    chk("wr_ack", 32'(ok), 32'd1);
    model_write(b, i, d, s);
  endtask

  task automatic rd_chk(input string tag, input int b, input int i);
    logic ok; logic [31:0] r;
    wb(1'b0, A(b, i), 32'd0, 4'hF, ok, r);
    chk({tag, "_ack"}, 32'(ok), 32'd1);
    chk(tag, r, model_read(b, i));
  endtask

  task automatic set_pads(input logic [W-1:0] nw);
    io_in = nw;
    model_pads(nw);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    logic [31:0] r, a, d;
    int op, b, i;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    check_pins("rst_in");
    @(posedge clk); #1; rst_n = 1'b1;
    check_pins("rst_out");
    chk("rst_oeb_ones", 32'(io_oeb), 32'h00FF_FFFF);
    rd_chk("b1_oeb_rst", 1, 1);
    chk("dat_idle", dat_o, 32'd0);

    // Reset in the middle of an acked write: ack drops at once, write is lost.
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A(0, 0); dat_i = 32'h55; sel = 4'hF;
    @(posedge clk); #1;
    chk("mr_ack_seen", 32'(ack), 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("mr_ack_drop", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();
    rd_chk("mr_lost", 0, 0);

    // Byte-lane write to bank2 OUT; single-cycle ack, pads update after the ack.
    wr(2, 0, 32'hFFFF_FFA5, 4'b0001);
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("b2_out_pads", 32'(io_out[23:16]), 32'hA5);
    wr(2, 0, 32'h0000_0011, 4'b0000);
    rd_chk("b2_out_sel0", 2, 0);

    // Input latency: a read started alongside the change still sees the old value.
    io_in[7:0] = 8'h3C;
    wb(1'b0, A(0, 2), 32'd0, 4'hF, ok, r);
    chk("in_early", r, 32'd0);
    model_pads(io_in);
    rd_chk("in_3c", 0, 2);
    chk("in_3c_abs", model_read(0, 2), 32'h3C);
    rd_chk("stat_3c", 0, 4);
    wr(0, 4, 32'hFF, 4'h1);
    rd_chk("stat_clr", 0, 4);

    // Interrupt path latency and W1C.
    wr(0, 3, 32'h01, 4'h1);
    io_in[0] = 1'b1;
    model_pads(io_in);
    repeat (3) @(posedge clk);
    #1 chk("irq_early", 32'(irq[0]), 32'd0);
    @(posedge clk);
    #1 chk("irq_set", 32'(irq[0]), 32'd1);
    rd_chk("stat_01", 0, 4);
    wr(0, 4, 32'h01, 4'h1);
    @(posedge clk);
    #1 chk("irq_clr", 32'(irq[0]), 32'd0);

    // Edge lands on the same cycle the W1C commits: the flag survives.
    io_in[0] = 1'b0;
    set_pads(io_in);
    io_in[0] = 1'b1;
    @(posedge clk); #1;
    wb(1'b1, A(0, 4), 32'h01, 4'h1, ok, r);
    chk("sw_ack", 32'(ok), 32'd1);
    model_write(0, 4, 32'h01, 4'h1);
    model_pads(io_in);
    rd_chk("set_wins", 0, 4);
    chk("set_wins_abs", model_read(0, 4), 32'h01);

    // Decode: outside the window is ignored, unmapped offsets read 0.
    wb(1'b0, BASE + 32'h200, 32'd0, 4'hF, ok, r);
    chk("miss_rd", 32'(ok), 32'd0);
    wb(1'b1, BASE + 32'h200, 32'hFF, 4'hF, ok, r);
    chk("miss_wr", 32'(ok), 32'd0);
    wb(1'b0, BASE + 32'h78, 32'd0, 4'hF, ok, r);
    chk("unmap_ack", 32'(ok), 32'd1);
    chk("unmap_rd", r, 32'd0);
    wr(0, 5, 32'h01, 4'h1);
    rd_chk("off14", 0, 5);
    check_pins("dir_end");

`ifdef IO_BANK_EDGE_SEL_EN
    wr(0, 4, 32'hFF, 4'h1);
    io_in[0] = 1'b0;
    set_pads(io_in);
    rd_chk("edge_fall", 0, 4);
    chk("edge_fall_abs", model_read(0, 4), 32'h01);
    wr(0, 4, 32'h01, 4'h1);
    io_in[0] = 1'b1;
    set_pads(io_in);
    rd_chk("edge_rise_ign", 0, 4);
    chk("edge_rise_abs", model_read(0, 4), 32'h00);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 9));
      b  = int'($urandom_range(0, 7));
      i  = int'($urandom_range(0, 7));
      a  = A(b, i) + 32'($urandom_range(0, 3));
      if (op <= 3) begin
        d = $urandom;
        sel = 4'($urandom_range(0, 15));
        wb(1'b1, a, d, sel, ok, r);
        chk("rnd_wr_ack", 32'(ok), 32'd1);
        model_write(b, i, d, sel);
      end else if (op <= 6) begin
        wb(1'b0, a, 32'd0, 4'hF, ok, r);
        chk("rnd_rd_ack", 32'(ok), 32'd1);
        chk("rnd_rd", r, model_read(b, i));
      end else if (op <= 8) begin
        set_pads(W'($urandom));
        check_pins("rnd_pins");
      end else begin
        a = a ^ (32'd1 << $urandom_range(8, 31));
        wb(1'b1, a, $urandom, 4'hF, ok, r);
        chk("rnd_miss", 32'(ok), 32'd0);
      end
    end
    repeat (2) @(posedge clk);
    #1 check_pins("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
